// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared defaults and encodings for the rotary quadrature filter
package rot_pkg;

  localparam int DEB_CYCLES_DEF = 50000;
  localparam int POS_W_DEF      = 8;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Debounced channel pair, indexed as {B, A}
  typedef enum logic [1:0] {
    CH_NONE   = 2'b00,
    CH_A_ONLY = 2'b01,
    CH_B_ONLY = 2'b10,
    CH_BOTH   = 2'b11
  } chan_e;

endpackage

// File: rtl/rot_quad_filter_if.sv
// rtl/rot_quad_filter_if.sv - encoder inputs and filtered step outputs
interface rot_quad_filter_if #(
  parameter int POS_W = rot_pkg::POS_W_DEF
);

  logic             ROT_A;
  logic             ROT_B;
  logic             rot_event;
  logic             rot_pulse;
  logic             rot_dir;
  logic [POS_W-1:0] position;

  modport master (
    input  ROT_A, ROT_B,
    output rot_event, rot_pulse, rot_dir, position
  );

  modport slave (
    output ROT_A, ROT_B,
    input  rot_event, rot_pulse, rot_dir, position
  );

endinterface

// File: rtl/rot_debounce.sv
// rtl/rot_debounce.sv - per-channel debounce counter and debounced level
module rot_debounce
  import rot_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  output logic level
);

  localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The level moves only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sample == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sample;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rot_quad_filter.sv
// rtl/rot_quad_filter.sv - synchronized, debounced quadrature decoder with step position
module rot_quad_filter
  import rot_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int POS_W      = POS_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  rot_quad_filter_if.master bus
);

  logic             a_s1, a_s2, b_s1, b_s2;
  logic             deb_a, deb_b;
  logic             q1, q2, q2_d;
  logic             event_r, pulse_r, dir_r;
  logic [POS_W-1:0] pos_r;
  logic             rise;
  logic             step_cw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= bus.ROT_A;
      a_s2 <= a_s1;
      b_s1 <= bus.ROT_B;
      b_s2 <= b_s1;
    end
  end

  rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (a_s2),
    .level  (deb_a)
  );

  rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (b_s2),
    .level  (deb_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1   <= 1'b0;
      q2   <= 1'b0;
      q2_d <= 1'b0;
    end else begin
      case (chan_e'({deb_b, deb_a}))
        CH_NONE:   q1 <= 1'b0;
        CH_BOTH:   q1 <= 1'b1;
        CH_A_ONLY: q2 <= 1'b0;
        CH_B_ONLY: q2 <= 1'b1;
        default:   ;
      endcase
      q2_d <= q2;
    end
  end

  // event_r is q1 one cycle late, so it doubles as the edge-detect history
  assign rise    = q1 & ~event_r;
  // q2 low at the detent means A led B, which is a clockwise step
  assign step_cw = (q2_d == 1'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_r <= 1'b0;
      pulse_r <= 1'b0;
      dir_r   <= DIR_CCW;
      pos_r   <= '0;
    end else begin
      event_r <= q1;
      pulse_r <= rise;
      if (rise) begin
        dir_r <= step_cw ? DIR_CW : DIR_CCW;
        pos_r <= step_cw ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
      end
    end
  end

  assign bus.rot_event = event_r;
  assign bus.rot_pulse = pulse_r;
  assign bus.rot_dir   = dir_r;
  assign bus.position  = pos_r;

endmodule

// File: tb/tb_rot_quad_filter.sv
// tb/tb_rot_quad_filter.sv - randomized self-checking bench for rot_quad_filter
module tb_rot_quad_filter;

  localparam int DEB = 4;
  localparam int PW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rot_quad_filter_if #(.POS_W(PW)) bus ();

  rot_quad_filter #(.DEB_CYCLES(DEB), .POS_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;

  // Reference: detent state machine evaluated on each settled input level
  logic          mq1 = 1'b0;
  logic          mq2 = 1'b0;
  logic          mdir = 1'b0;
  logic [PW-1:0] mpos = '0;
  int            exp_pulses = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rot_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input logic b, input logic a);
    logic old_q1;
    old_q1 = mq1;
    if (!b && !a) mq1 = 1'b0;
    else if (b && a) mq1 = 1'b1;
    else mq2 = b;
    if (!old_q1 && mq1) begin
      exp_pulses++;
      mdir = (mq2 == 1'b0);
      mpos = mdir ? mpos + 8'd1 : mpos - 8'd1;
    end
  endtask

  task automatic model_reset();
    mq1  = 1'b0;
    mq2  = 1'b0;
    mdir = 1'b0;
    mpos = '0;
  endtask

  task automatic drive(input logic b, input logic a, input int hold);
    bus.ROT_A = a;
    bus.ROT_B = b;
    step(hold);
    if (hold >= 6) model_apply(b, a);
  endtask

  task automatic do_reset(input logic b, input logic a);
    rst_n = 1'b0;
    bus.ROT_A = a;
    bus.ROT_B = b;
    step(3);
    model_reset();
    rst_n = 1'b1;
    step(14);
    model_apply(b, a);
  endtask

  task automatic test_reset();
    bus.ROT_A = 1'b1;
    bus.ROT_B = 1'b1;
    rst_n = 1'b0;
    step(3);
    checks++; if (bus.rot_event !== 1'b0) begin errors++; $display("FAIL reset_event: got %b expected 0", bus.rot_event); end
    checks++; if (bus.rot_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", bus.rot_pulse); end
    checks++; if (bus.rot_dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", bus.rot_dir); end
    checks++; if (bus.position !== 8'h00) begin errors++; $display("FAIL reset_pos: got %h expected 00", bus.position); end
    bus.ROT_A = 1'b0;
    bus.ROT_B = 1'b0;
    rst_n = 1'b1;
    step(14);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL reset_release_pulse: got %0d expected %0d", pulse_cnt, exp_pulses); end
  endtask

  task automatic test_release_detent();
    do_reset(1'b1, 1'b1);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL release11_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL release11_pos: got %h expected %h", bus.position, mpos); end
    checks++; if (bus.rot_event !== mq1) begin errors++; $display("FAIL release11_event: got %b expected %b", bus.rot_event, mq1); end
  endtask

  task automatic test_cw();
    do_reset(1'b0, 1'b0);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 12);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL cw_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    checks++; if (bus.rot_dir !== mdir) begin errors++; $display("FAIL cw_dir: got %b expected %b", bus.rot_dir, mdir); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL cw_pos: got %h expected %h", bus.position, mpos); end
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 12);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL cw_fall_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
  endtask

  task automatic test_ccw();
    do_reset(1'b0, 1'b0);
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 12);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL ccw_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    checks++; if (bus.rot_dir !== mdir) begin errors++; $display("FAIL ccw_dir: got %b expected %b", bus.rot_dir, mdir); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL ccw_pos: got %h expected %h", bus.position, mpos); end
  endtask

  task automatic test_latency();
    int start;
    drive(1'b0, 1'b0, 14);
    start = cyc;
    drive(1'b1, 1'b1, 14);
    checks++; if (last_pulse_cyc - start !== 2 + DEB + 2) begin errors++; $display("FAIL latency: got %0d expected %0d", last_pulse_cyc - start, 2 + DEB + 2); end
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL latency_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL simul_pos: got %h expected %h", bus.position, mpos); end
  endtask

  task automatic test_bounce();
    drive(1'b0, 1'b0, 14);
    bus.ROT_A = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ROT_A = ~bus.ROT_A;
      step(2);
    end
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL bounce_quiet: got %0d expected %0d", pulse_cnt, exp_pulses); end
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 14);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL bounce_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    checks++; if (bus.rot_dir !== mdir) begin errors++; $display("FAIL bounce_dir: got %b expected %b", bus.rot_dir, mdir); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL bounce_pos: got %h expected %h", bus.position, mpos); end
  endtask

  task automatic test_glitch();
    drive(1'b1, 1'b0, 12);
    drive(1'b0, 1'b0, 14);
    bus.ROT_A = 1'b1;
    step(3);
    bus.ROT_A = 1'b0;
    step(14);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL glitch_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    checks++; if (bus.rot_event !== mq1) begin errors++; $display("FAIL glitch_event: got %b expected %b", bus.rot_event, mq1); end
    checks++; if (bus.rot_dir !== mdir) begin errors++; $display("FAIL glitch_dir: got %b expected %b", bus.rot_dir, mdir); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL glitch_pos: got %h expected %h", bus.position, mpos); end
  endtask

  task automatic test_mid_reset();
    bus.ROT_A = 1'b1;
    bus.ROT_B = 1'b0;
    step(4);
    rst_n = 1'b0;
    bus.ROT_A = 1'b0;
    step(2);
    model_reset();
    checks++; if (bus.rot_event !== mq1) begin errors++; $display("FAIL midrst_event: got %b expected %b", bus.rot_event, mq1); end
    checks++; if (bus.rot_dir !== mdir) begin errors++; $display("FAIL midrst_dir: got %b expected %b", bus.rot_dir, mdir); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL midrst_pos: got %h expected %h", bus.position, mpos); end
    rst_n = 1'b1;
    step(15);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL midrst_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
  endtask

  task automatic test_wrap();
    int base;
    do_reset(1'b0, 1'b0);
    base = pulse_cnt;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 8);
      drive(1'b1, 1'b1, 8);
      drive(1'b1, 1'b0, 8);
      drive(1'b0, 1'b0, 8);
    end
    step(12);
    checks++; if (pulse_cnt - base !== 256) begin errors++; $display("FAIL wrap_pulses: got %0d expected 256", pulse_cnt - base); end
    checks++; if (bus.position !== mpos) begin errors++; $display("FAIL wrap_pos: got %h expected %h", bus.position, mpos); end
  endtask

  task automatic test_random();
    logic a, b, cur_a;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 25; s++) begin
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          cur_a = bus.ROT_A;
          bus.ROT_A = ~cur_a;
          step($urandom_range(1, 3));
          bus.ROT_A = cur_a;
          step(5);
        end
        drive(b, a, $urandom_range(6, 12));
      end
      step(14);
      checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL rand%0d_pulses: got %0d expected %0d", r, pulse_cnt, exp_pulses); end
      checks++; if (bus.rot_dir !== mdir) begin errors++; $display("FAIL rand%0d_dir: got %b expected %b", r, bus.rot_dir, mdir); end
      checks++; if (bus.position !== mpos) begin errors++; $display("FAIL rand%0d_pos: got %h expected %h", r, bus.position, mpos); end
      checks++; if (bus.rot_event !== mq1) begin errors++; $display("FAIL rand%0d_event: got %b expected %b", r, bus.rot_event, mq1); end
    end
  endtask

  initial begin
    bus.ROT_A = 1'b0;
    bus.ROT_B = 1'b0;
    test_reset();
    test_release_detent();
    test_cw();
    test_ccw();
    test_latency();
    test_bounce();
    test_glitch();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rot_quad_filter.md
ROT_QUAD_FILTER -- requirements
Module: rot_quad_filter

Interface
REQ-001 Parameter DEB_CYCLES, default 50000, is the number of consecutive clk cycles an input must hold a new value before it is accepted (0.5 ms at 100 MHz).
REQ-002 Parameter POS_W, default 8, is the width of the position counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ROT_A  input  1  raw rotary channel A (asynchronous, bouncy).
REQ-006 ROT_B  input  1  raw rotary channel B (asynchronous, bouncy).
REQ-007 rot_event  output  1  filtered detent level (q1); its rising edge marks one detent step.
REQ-008 rot_pulse  output  1  one-cycle strobe on each rising edge of rot_event.
REQ-009 rot_dir  output  1  direction of the last step: 1 = clockwise, 0 = counter-clockwise.
REQ-010 position  output  POS_W  signed step count, +1 per CW step, -1 per CCW step.

Function
REQ-011 ROT_A and ROT_B SHALL each pass through a two-flop synchronizer before any other logic.
REQ-012 Each synchronized channel SHALL have its own debounce counter; a differing sample increments it, a matching sample clears it, and the debounced value updates when the count reaches DEB_CYCLES-1.
REQ-013 Debounced {B,A} SHALL drive q1/q2: 00 -> q1=0; 11 -> q1=1; 01 -> q2=0; 10 -> q2=1; q1 and q2 otherwise hold.
REQ-014 rot_event SHALL equal q1, registered.
REQ-015 rot_pulse SHALL assert for exactly one cycle, the cycle after q1 goes 0->1; it SHALL NOT assert on q1 falling.
REQ-016 On rot_pulse, rot_dir SHALL capture q2 as it was one cycle before q1 rose (q2 delayed one cycle); rot_dir holds between pulses.
REQ-017 position SHALL update in the same cycle as rot_pulse, using the newly captured direction, and wraps modulo 2^POS_W with no saturation.
REQ-018 Latency: debounced-input change to rot_pulse SHALL be fixed at 2 synchronizer + DEB_CYCLES + 2 cycles.
REQ-019 A glitch shorter than DEB_CYCLES cycles on either channel SHALL produce no change on any output.
REQ-020 Simultaneous debounced changes on A and B SHALL be resolved by the REQ-013 table using both new values in the same cycle.
REQ-021 DEB_CYCLES = 1 SHALL accept every synchronized change on the next cycle (no filtering).

Reset
REQ-022 While rst_n = 0: synchronizers, debounced values, q1, q2, delayed q2, and all counters SHALL be 0; rot_event = 0, rot_pulse = 0, rot_dir = 0, position = 0.
REQ-023 Reset asserted mid-debounce or mid-step SHALL discard the partial count; no pulse SHALL be emitted as a result of reset release.
REQ-024 After rst_n rises with ROT_A = ROT_B = 1 held, q1 rising SHALL produce one rot_pulse (a legitimate detent), after the REQ-018 latency.

Structure
REQ-025 The debounce counter plus its debounced output SHALL be one sub-module, rot_debounce, instantiated once per channel.
REQ-026 DEB_CYCLES default, POS_W default and the direction encoding constants (DIR_CW = 1, DIR_CCW = 0) SHALL reside in a shared package rot_pkg.
REQ-027 Counter width in rot_debounce SHALL be derived from DEB_CYCLES (clog2), not hard-coded.
REQ-028 rot_event SHALL stay pin-compatible with the existing downstream consumer, which edge-detects it; rot_pulse, rot_dir and position are additive.

Verification (bench uses DEB_CYCLES = 4, POS_W = 8)
REQ-029 CW step: from {B,A}=00, A->1, wait 10 cycles, B->1 -> one rot_pulse, rot_dir = 1, position 0 -> 1.
REQ-030 CCW step: from 00, B->1, wait 10, A->1 -> one rot_pulse, rot_dir = 0, position 0 -> 0xFF.
REQ-031 Bounce: A toggles every 2 cycles for 20 cycles then settles 1, B then to 1 -> exactly one rot_pulse, no extra pulses.
REQ-032 Wrap: 256 CW steps from reset -> position returns to 0x00, 256 rot_pulses counted.
REQ-033 Glitch: 3-cycle high pulse on A with B = 0 -> all outputs unchanged.
REQ-034 Reset mid-step: assert rst_n low while A stable 2 cycles into debounce -> all outputs 0, no rot_pulse after release with inputs 00.
